// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: shares one single-port framebuffer RAM between the VGA line
// fetcher and a writer port.
//
// A line_req starts a burst of LINE_WORDS sequential reads from line_base.
// Each returned word is written into the line buffer one cycle later. The
// writer is granted whenever the port is not carrying a scan read.
//
// Optional feature macro: VGA_FB_ARB_FAIR_EN. When it is defined, the writer
// gets one slot every FAIR_PERIOD cycles during a fill. When it is undefined,
// scan reads have absolute priority.
//
// Ports:
//   clk, rst                  pixel clock, async active-high reset
//   line_req, line_base       line fetch request and first word address
//   line_wr_en/addr/data      line buffer write port
//   fill_busy, fill_done      fill in progress / pulse with last line write
//   overrun, ovr_clr          sticky "request while busy" flag and its clear
//   wr_valid/addr/data/ready  writer handshake
//   ram_en/we/addr/wdata      RAM command (read data returns next cycle)
//   ram_rdata                 RAM read data
module vga_fb_arbiter #(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DATA_W      = 12,
  parameter int unsigned LINE_WORDS  = 640,
  parameter int unsigned FAIR_PERIOD = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          line_req,
  input  logic [ADDR_W-1:0]             line_base,
  output logic                          line_wr_en,
  output logic [$clog2(LINE_WORDS)-1:0] line_wr_addr,
  output logic [DATA_W-1:0]             line_wr_data,
  output logic                          fill_busy,
  output logic                          fill_done,
  output logic                          overrun,
  input  logic                          ovr_clr,
  input  logic                          wr_valid,
  input  logic [ADDR_W-1:0]             wr_addr,
  input  logic [DATA_W-1:0]             wr_data,
  output logic                          wr_ready,
  output logic                          ram_en,
  output logic                          ram_we,
  output logic [ADDR_W-1:0]             ram_addr,
  output logic [DATA_W-1:0]             ram_wdata,
  input  logic [DATA_W-1:0]             ram_rdata
);

  localparam int unsigned IdxW = $clog2(LINE_WORDS);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(LINE_WORDS - 1);

  typedef enum logic [1:0] {StIdle, StFill, StLast} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic                rd_valid_q;
  logic [IdxW-1:0]     rd_idx_q;
  logic                overrun_q, overrun_d;

  logic                scan_rd;
  logic                fair_slot;
  logic                wr_fire;

`ifdef VGA_FB_ARB_FAIR_EN
  localparam int unsigned FairW = $clog2(FAIR_PERIOD);
  localparam logic [FairW-1:0] FairTop = FairW'(FAIR_PERIOD - 1);

  logic [FairW-1:0] fair_cnt_q, fair_cnt_d;

  // A slot is only taken when the writer actually wants it; otherwise the
  // counter stays saturated and the scan keeps going.
  assign fair_slot = (state_q == StFill) && (fair_cnt_q == FairTop) && wr_valid;

  always_comb begin
    fair_cnt_d = fair_cnt_q;
    if (state_q == StIdle && line_req) begin
      fair_cnt_d = '0;
    end else if (state_q == StFill) begin
      if (fair_slot) begin
        fair_cnt_d = '0;
      end else if (fair_cnt_q != FairTop) begin
        fair_cnt_d = fair_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fair_cnt_q <= '0;
    end else begin
      fair_cnt_q <= fair_cnt_d;
    end
  end
`else
  assign fair_slot = 1'b0;
`endif

  assign scan_rd  = (state_q == StFill) && !fair_slot;
  // Held low during reset so no write can slip through while state is forced.
  assign wr_ready = !rst && !scan_rd;
  assign wr_fire  = wr_valid && wr_ready;

  assign ram_en    = scan_rd || wr_fire;
  assign ram_we    = wr_fire;
  assign ram_addr  = scan_rd ? (base_q + ADDR_W'(idx_q)) : wr_addr;
  assign ram_wdata = wr_data;

  // RAM has one cycle of read latency, so the line write trails the read.
  assign line_wr_en   = rd_valid_q;
  assign line_wr_addr = rd_idx_q;
  assign line_wr_data = ram_rdata;

  assign fill_busy = (state_q != StIdle);
  assign fill_done = (state_q == StLast);
  assign overrun   = overrun_q;

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    idx_d   = idx_q;
    unique case (state_q)
      StIdle: begin
        if (line_req) begin
          state_d = StFill;
          base_d  = line_base;
          idx_d   = '0;
        end
      end
      StFill: begin
        if (scan_rd) begin
          idx_d = idx_q + 1'b1;
          if (idx_q == IdxLast) begin
            state_d = StLast;
          end
        end
      end
      StLast: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // A new overrun event wins over a same-cycle clear.
  always_comb begin
    overrun_d = (overrun_q && !ovr_clr) || (line_req && (state_q != StIdle));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      base_q     <= '0;
      idx_q      <= '0;
      rd_valid_q <= 1'b0;
      rd_idx_q   <= '0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      idx_q      <= idx_d;
      rd_valid_q <= scan_rd;
      rd_idx_q   <= idx_q;
      overrun_q  <= overrun_d;
    end
  end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Testbench for vga_fb_arbiter (LINE_WORDS=8, FAIR_PERIOD=4).
// Stimulus pushes expected RAM reads, RAM writes, line writes and fill_done
// pulses (with their cycle numbers) into queues; a negedge monitor pops and
// compares whenever the DUT presents one of those events.
module tb_vga_fb_arbiter;

  localparam int unsigned LineWords = 8;

`ifdef VGA_FB_ARB_FAIR_EN
  localparam bit Fair = 1'b1;
`else
  localparam bit Fair = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        line_req;
  logic [15:0] line_base;
  logic        line_wr_en;
  logic [2:0]  line_wr_addr;
  logic [11:0] line_wr_data;
  logic        fill_busy;
  logic        fill_done;
  logic        overrun;
  logic        ovr_clr;
  logic        wr_valid;
  logic [15:0] wr_addr;
  logic [11:0] wr_data;
  logic        wr_ready;
  logic        ram_en;
  logic        ram_we;
  logic [15:0] ram_addr;
  logic [11:0] ram_wdata;
  logic [11:0] ram_rdata;

  vga_fb_arbiter #(
    .ADDR_W     (16),
    .DATA_W     (12),
    .LINE_WORDS (LineWords),
    .FAIR_PERIOD(4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .line_req    (line_req),
    .line_base   (line_base),
    .line_wr_en  (line_wr_en),
    .line_wr_addr(line_wr_addr),
    .line_wr_data(line_wr_data),
    .fill_busy   (fill_busy),
    .fill_done   (fill_done),
    .overrun     (overrun),
    .ovr_clr     (ovr_clr),
    .wr_valid    (wr_valid),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_ready    (wr_ready),
    .ram_en      (ram_en),
    .ram_we      (ram_we),
    .ram_addr    (ram_addr),
    .ram_wdata   (ram_wdata),
    .ram_rdata   (ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Framebuffer model: one-cycle read latency.
  logic [11:0] mem [0:65535];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata     <= mem[ram_addr];
    end
  end

  function automatic logic [11:0] pattern(input logic [15:0] a);
    return a[11:0] ^ {a[15:12], 8'h5C};
  endfunction

  logic [11:0] wrote [int];

  function automatic logic [11:0] exp_word(input logic [15:0] a);
    if (wrote.exists(int'(a))) return wrote[int'(a)];
    return pattern(a);
  endfunction

  typedef struct {
    int          cyc;
    logic [15:0] addr;
    logic [11:0] data;
  } ev_t;

  ev_t rd_q[$];
  ev_t wr_q[$];
  ev_t lw_q[$];
  int  done_q[$];

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: got unexpected event expected none (cycle %0d)", name, cyc);
  endtask

  // Expected schedule of one fill started in the current cycle. With stretch,
  // writer slots sit at t+4 and t+8 (FAIR_PERIOD=4, writer always valid).
  task automatic push_fill(input logic [15:0] base, input int nrd, input int nlw,
                           input bit done, input bit stretch);
    int  rc;
    ev_t e;
    ev_t l;
    rc = cyc;
    for (int i = 0; i < LineWords; i++) begin
      rc++;
      if (stretch && (i == 3 || i == 6)) rc++;
      e.cyc  = rc;
      e.addr = base + 16'(i);
      e.data = exp_word(e.addr);
      if (i < nrd) rd_q.push_back(e);
      if (i < nlw) begin
        l.cyc  = rc + 1;
        l.addr = 16'(i);
        l.data = e.data;
        lw_q.push_back(l);
      end
    end
    if (done) done_q.push_back(rc + 1);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_fill(input logic [15:0] base, input int nrd, input int nlw,
                            input bit done, input bit stretch);
    line_req  = 1'b1;
    line_base = base;
    push_fill(base, nrd, nlw, done, stretch);
  endtask

  task automatic plain_fill(input logic [15:0] base);
    start_fill(base, 8, 8, 1'b1, 1'b0);
    tick();
    line_req = 1'b0;
    repeat (12) tick();
  endtask

  // Monitor: compares every DUT output event against the queues.
  always @(negedge clk) begin
    ev_t e;
    int  d;
    if (ram_en && !ram_we) begin
      if (rd_q.size() == 0) unexpected("scan_read");
      else begin
        e = rd_q.pop_front();
        chk("scan_read_cycle", cyc, e.cyc);
        chk("scan_read_addr", ram_addr, e.addr);
      end
    end
    if (ram_en && ram_we) begin
      if (wr_q.size() == 0) unexpected("ram_write");
      else begin
        e = wr_q.pop_front();
        chk("ram_write_cycle", cyc, e.cyc);
        chk("ram_write_addr", ram_addr, e.addr);
        chk("ram_write_data", ram_wdata, e.data);
      end
    end
    if (line_wr_en) begin
      if (lw_q.size() == 0) unexpected("line_write");
      else begin
        e = lw_q.pop_front();
        chk("line_write_cycle", cyc, e.cyc);
        chk("line_write_addr", line_wr_addr, e.addr);
        chk("line_write_data", line_wr_data, e.data);
      end
    end
    if (fill_done) begin
      if (done_q.size() == 0) unexpected("fill_done");
      else begin
        d = done_q.pop_front();
        chk("fill_done_cycle", cyc, d);
      end
    end
  end

  initial begin
    ev_t w;
    bit  acc;
    for (int a = 0; a < 65536; a++) mem[a] = pattern(16'(a));
    rst = 1'b0; line_req = 1'b0; line_base = '0; ovr_clr = 1'b0;
    wr_valid = 1'b1; wr_addr = 16'h1234; wr_data = 12'hABC;
    #1 rst = 1'b1;
    #2;
    chk("reset_fill_busy", fill_busy, 1'b0);
    chk("reset_fill_done", fill_done, 1'b0);
    chk("reset_overrun", overrun, 1'b0);
    chk("reset_line_wr_en", line_wr_en, 1'b0);
    chk("reset_ram_en", ram_en, 1'b0);
    chk("reset_ram_we", ram_we, 1'b0);
    chk("reset_wr_ready", wr_ready, 1'b0);
    tick(); tick();
    wr_valid = 1'b0;
    rst = 1'b0;
    tick();

    // Basic fill with overrun handling; base 0x0100.
    for (int k = 0; k <= 12; k++) begin
      if (k > 0) tick();
      line_req = 1'b0;
      ovr_clr  = 1'b0;
      if (k == 0) start_fill(16'h0100, 8, 8, 1'b1, 1'b0);
      if (k == 3) begin line_req = 1'b1; line_base = 16'h0AAA; end
      if (k == 6) begin line_req = 1'b1; ovr_clr = 1'b1; end
      if (k == 8) ovr_clr = 1'b1;
      #1;
      chk("fill_busy", fill_busy, (k >= 1 && k <= 9));
      chk("overrun", overrun, (k >= 4 && k <= 8));
    end
    line_req = 1'b0;
    ovr_clr  = 1'b0;
    tick();

    // Address wrap.
    plain_fill(16'hFFFC);

    // Writer contention: writer valid from t through t+11, line_req at t.
    for (int k = 0; k < 12; k++) begin
      if (k > 0) tick();
      line_req = 1'b0;
      if (k == 0) start_fill(16'h0500, 8, 8, 1'b1, Fair);
      wr_valid = 1'b1;
      wr_addr  = 16'h0400 + 16'(k);
      wr_data  = 12'h700 + 12'(k);
      acc = (k == 0) || (Fair ? (k == 4 || k == 8 || k == 11) : (k >= 9));
      if (acc) begin
        wrote[int'(wr_addr)] = wr_data;
        w.cyc  = cyc;
        w.addr = wr_addr;
        w.data = wr_data;
        wr_q.push_back(w);
      end
      #1;
      chk("wr_ready", wr_ready, acc);
    end
    tick();
    wr_valid = 1'b0;
    tick();

    // Read back the written words through later fills.
    plain_fill(16'h0400);
    plain_fill(16'h0404);

    // Reset mid-fill: reset lands at t+4, after reads of idx 0..2.
    for (int k = 0; k <= 4; k++) begin
      if (k > 0) tick();
      line_req = 1'b0;
      if (k == 0) start_fill(16'h0200, 3, 2, 1'b0, 1'b0);
      if (k == 2) begin line_req = 1'b1; line_base = 16'h0777; end
      if (k == 3) begin #1; chk("overrun_before_reset", overrun, 1'b1); end
    end
    rst = 1'b1;
    #1;
    chk("midreset_fill_busy", fill_busy, 1'b0);
    chk("midreset_fill_done", fill_done, 1'b0);
    chk("midreset_overrun", overrun, 1'b0);
    chk("midreset_line_wr_en", line_wr_en, 1'b0);
    chk("midreset_ram_en", ram_en, 1'b0);
    wr_valid = 1'b1;
    #1;
    chk("midreset_wr_ready", wr_ready, 1'b0);
    chk("midreset_ram_we", ram_we, 1'b0);
    tick(); tick();
    wr_valid = 1'b0;
    rst = 1'b0;
    tick();
    plain_fill(16'h0200);

    repeat (4) tick();
    chk("rd_queue_drained", rd_q.size(), 0);
    chk("wr_queue_drained", wr_q.size(), 0);
    chk("lw_queue_drained", lw_q.size(), 0);
    chk("done_queue_drained", done_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
